// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, branch squash, debug halt/drain/step FSM, perf counters.
// Latency: control outputs are combinational (zero cycles from hazard to stall); state and counters update on the next edge.
// Backpressure: stalls freeze PC and IF/ID while ID/EX takes a bubble; drain keeps inserting bubbles until halted.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch_taken,
    input  logic             id_halt_instr,
    input  logic             ex_m_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             dbg_halt_req,
    input  logic             dbg_step_req,
    input  logic             dbg_resume,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP} state_t;

    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] drain_cnt, drain_nxt;
    logic       step_q;
    logic       hazard;
    logic       stall_inc;

    assign hazard = ex_m_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_nxt   = state;
        drain_nxt   = drain_cnt;
        stall_inc   = 1'b0;
        case (state)
            RUN, STEP: begin
                if (hazard) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    stall_inc   = 1'b1;
                end else if (id_halt_instr) begin
                    // HALT is squashed in ID so it never reaches EX
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_nxt   = DRAIN;
                end else if (state == RUN && dbg_halt_req) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    state_nxt   = DRAIN;
                end else begin
                    if_id_flush = id_branch_taken;
                    if (state == STEP) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    drain_nxt = 3'd0;
                    state_nxt = HALTED;
                end else begin
                    drain_nxt = drain_cnt + 3'd1;
                end
            end
            default: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                if (dbg_resume)                  state_nxt = RUN;
                else if (dbg_step_req && !step_q) state_nxt = STEP;
            end
        endcase
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            drain_cnt   <= 3'd0;
            step_q      <= 1'b0;
            cycle_count <= '0;
            stall_count <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            step_q    <= dbg_step_req;
            if (state != HALTED && cycle_count != '1)
                cycle_count <= cycle_count + CNT_W'(1);
            if (stall_inc && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign halted = (state == HALTED);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second 4-bit-counter instance exercises saturation.
module tb_pipeline_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, id_branch_taken, id_halt_instr, ex_m_mem_read;
    logic       dbg_halt_req, dbg_step_req, dbg_resume;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, halted;
    logic [31:0] cycle_count, stall_count;
    logic       s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_halted;
    logic [3:0] s_cycle_count, s_stall_count;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch_taken(id_branch_taken), .id_halt_instr(id_halt_instr),
        .ex_m_mem_read(ex_m_mem_read), .ex_rt(ex_rt), .dbg_halt_req(dbg_halt_req),
        .dbg_step_req(dbg_step_req), .dbg_resume(dbg_resume), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .halted(halted), .cycle_count(cycle_count), .stall_count(stall_count)
    );

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch_taken(id_branch_taken), .id_halt_instr(id_halt_instr),
        .ex_m_mem_read(ex_m_mem_read), .ex_rt(ex_rt), .dbg_halt_req(dbg_halt_req),
        .dbg_step_req(dbg_step_req), .dbg_resume(dbg_resume), .pc_write(s_pc_write),
        .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .halted(s_halted), .cycle_count(s_cycle_count), .stall_count(s_stall_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; id_branch_taken = 1'b0; id_halt_instr = 1'b0;
        ex_m_mem_read = 1'b0; dbg_halt_req = 1'b0; dbg_step_req = 1'b0; dbg_resume = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        #2;
        total++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b0011) begin
            bad++; $display("FAIL rst_ctrl got=%b want=0011", {pc_write, if_id_write, if_id_flush, id_ex_flush}); end
        tick();
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", halted); end
        total++; if (cycle_count !== 32'd0 || stall_count !== 32'd0) begin
            bad++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", cycle_count, stall_count); end
        reset = 1'b0;
        #1;
        total++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1100) begin
            bad++; $display("FAIL rst_adv got=%b want=1100", {pc_write, if_id_write, if_id_flush, id_ex_flush}); end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_m_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        total++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b0001) begin
            bad++; $display("FAIL lu_stall got=%b want=0001", {pc_write, if_id_write, if_id_flush, id_ex_flush}); end
        tick();
        clear_inputs();
        #1;
        total++; if (stall_count !== 32'd1 || cycle_count !== 32'd1) begin
            bad++; $display("FAIL lu_cnt got=%0d/%0d want=1/1", stall_count, cycle_count); end
        ex_m_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        total++; if (pc_write !== 1'b1 || id_ex_flush !== 1'b0) begin
            bad++; $display("FAIL lu_r0 got=%b%b want=10", pc_write, id_ex_flush); end
        tick();
        total++; if (stall_count !== 32'd1) begin bad++; $display("FAIL lu_r0_cnt got=%0d want=1", stall_count); end
        clear_inputs();
    endtask

    task automatic test_uses_rt();
        do_reset();
        ex_m_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        total++; if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            bad++; $display("FAIL rt_gate0 got=%b%b want=11", pc_write, if_id_write); end
        id_uses_rt = 1'b1;
        #1;
        total++; if (pc_write !== 1'b0 || if_id_write !== 1'b0 || id_ex_flush !== 1'b1) begin
            bad++; $display("FAIL rt_gate1 got=%b%b%b want=001", pc_write, if_id_write, id_ex_flush); end
        tick();
        total++; if (stall_count !== 32'd1) begin bad++; $display("FAIL rt_cnt got=%0d want=1", stall_count); end
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        id_branch_taken = 1'b1;
        #1;
        total++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1110) begin
            bad++; $display("FAIL br_flush got=%b want=1110", {pc_write, if_id_write, if_id_flush, id_ex_flush}); end
        ex_m_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        #1;
        total++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b0001) begin
            bad++; $display("FAIL br_hazard got=%b want=0001", {pc_write, if_id_write, if_id_flush, id_ex_flush}); end
        clear_inputs();
    endtask

    task automatic test_dbg_halt();
        do_reset();
        dbg_halt_req = 1'b1;
        #1;
        total++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b0001) begin
            bad++; $display("FAIL dh_entry got=%b want=0001", {pc_write, if_id_write, if_id_flush, id_ex_flush}); end
        tick();
        dbg_halt_req = 1'b0;
        ex_m_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (halted !== 1'b0 || pc_write !== 1'b0 || id_ex_flush !== 1'b1 || if_id_flush !== 1'b0) begin
                bad++; $display("FAIL dh_drain%0d got=h%b p%b x%b f%b want=h0 p0 x1 f0", i, halted, pc_write, id_ex_flush, if_id_flush); end
            tick();
        end
        clear_inputs();
        #1;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL dh_halted got=%b want=1", halted); end
        total++; if (cycle_count !== 32'd4 || stall_count !== 32'd0) begin
            bad++; $display("FAIL dh_cnt got=%0d/%0d want=4/0", cycle_count, stall_count); end
        tick();
        tick();
        total++; if (cycle_count !== 32'd4 || halted !== 1'b1) begin
            bad++; $display("FAIL dh_freeze got=%0d h%b want=4 h1", cycle_count, halted); end
    endtask

    task automatic test_step();
        int pulses;
        pulses = 0;
        dbg_step_req = 1'b1;
        #1;
        total++; if (halted !== 1'b1 || pc_write !== 1'b0) begin
            bad++; $display("FAIL st_pre got=h%b p%b want=h1 p0", halted, pc_write); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pc_write === 1'b1) pulses++;
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL st_pulses got=%0d want=1", pulses); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL st_rehalt got=%b want=1", halted); end
        tick();
        total++; if (halted !== 1'b1 || pc_write !== 1'b0) begin
            bad++; $display("FAIL st_level got=h%b p%b want=h1 p0", halted, pc_write); end
        dbg_step_req = 1'b0;
        total++; if (cycle_count !== 32'd8) begin bad++; $display("FAIL st_cnt got=%0d want=8", cycle_count); end
        dbg_resume = 1'b1;
        #1;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL st_resume_pre got=%b want=1", halted); end
        tick();
        dbg_resume = 1'b0;
        #1;
        total++; if (halted !== 1'b0 || pc_write !== 1'b1 || cycle_count !== 32'd8) begin
            bad++; $display("FAIL st_resume got=h%b p%b c%0d want=h0 p1 c8", halted, pc_write, cycle_count); end
    endtask

    task automatic test_halt_instr_reset();
        do_reset();
        id_halt_instr = 1'b1; dbg_halt_req = 1'b1;
        #1;
        total++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b0111) begin
            bad++; $display("FAIL hi_squash got=%b want=0111", {pc_write, if_id_write, if_id_flush, id_ex_flush}); end
        tick();
        clear_inputs();
        #1;
        total++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b0001) begin
            bad++; $display("FAIL hi_drain got=%b want=0001", {pc_write, if_id_write, if_id_flush, id_ex_flush}); end
        tick();
        reset = 1'b1;
        #1;
        total++; if (if_id_flush !== 1'b1 || pc_write !== 1'b0 || cycle_count !== 32'd0 || halted !== 1'b0) begin
            bad++; $display("FAIL hi_rst got=f%b p%b c%0d h%b want=f1 p0 c0 h0", if_id_flush, pc_write, cycle_count, halted); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++; if (halted !== 1'b0 || pc_write !== 1'b1 || cycle_count !== 32'd4) begin
            bad++; $display("FAIL hi_run got=h%b p%b c%0d want=h0 p1 c4", halted, pc_write, cycle_count); end
    endtask

    task automatic test_saturate();
        do_reset();
        ex_m_mem_read = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
        for (int i = 0; i < 20; i++) tick();
        total++; if (s_cycle_count !== 4'hF || s_stall_count !== 4'hF) begin
            bad++; $display("FAIL sat_small got=%0d/%0d want=15/15", s_cycle_count, s_stall_count); end
        total++; if (cycle_count !== 32'd20 || stall_count !== 32'd20) begin
            bad++; $display("FAIL sat_wide got=%0d/%0d want=20/20", cycle_count, stall_count); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_uses_rt();
        test_branch();
        test_dbg_halt();
        test_step();
        test_halt_instr_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
